ysyx_22050612_load_store_unit: RTL and testbench

Multi-cycle load/store unit sitting directly downstream of the execute stage. It accepts one memory operation per transaction from EXU: effective address, store data, size, signedness and destination register. It drives a valid/ready request/response memory port with byte-lane alignment and write masks, and returns the extended load value with a register write enable to the write-back path. It replaces the combinational DPI memory access with a bus transaction that tolerates stalls on either side.

---
 rtl/ysyx_22050612_load_store_unit.sv | 143 ++++++++++++++
 tb/tb_ysyx_22050612_load_store_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050612_load_store_unit.sv
// Multi-cycle load/store unit: takes one memory operation from EXU, issues it on a
// valid/ready memory port with byte-lane alignment, and returns the extended load result.
module ysyx_22050612_load_store_unit #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_wen,
   input  logic [1:0]        in_size,
   input  logic              in_unsigned,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_wdata,
   input  logic [4:0]        in_rd,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic              mem_req_wen,
   output logic [DATA_W-1:0] mem_req_wdata,
   output logic [7:0]        mem_req_wmask,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [4:0]        out_rd,
   output logic [DATA_W-1:0] out_rdata,
   output logic              out_wen,
   output logic              out_misaligned
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic [7:0]        wmask_reg;
   logic              wen_reg;
   logic [1:0]        size_reg;
   logic              unsigned_reg;
   logic [2:0]        off_reg;
   logic [4:0]        rd_reg;
   logic [DATA_W-1:0] rdata_reg;
   logic              out_wen_reg;
   logic              misaligned_reg;

   logic              accept;
   logic              misaligned;
   logic [7:0]        base_mask;
   logic [7:0]        lane_mask;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] load_value;

   assign in_ready = (state_reg == IDLE);
   assign accept   = in_valid && in_ready;

   // Alignment check and byte-enable pattern both follow directly from the access size.
   always_comb begin
      misaligned = 1'b0;
      base_mask  = 8'hFF;
      case (in_size)
         2'd0: begin misaligned = 1'b0;           base_mask = 8'h01; end
         2'd1: begin misaligned = in_addr[0];     base_mask = 8'h03; end
         2'd2: begin misaligned = |in_addr[1:0];  base_mask = 8'h0F; end
         default: begin misaligned = |in_addr[2:0]; base_mask = 8'hFF; end
      endcase
   end

   assign lane_mask = base_mask << in_addr[2:0];

   // Bring the addressed bytes down to bit 0, then slice and extend by size.
   assign shifted = mem_resp_rdata >> {off_reg, 3'b000};

   always_comb begin
      load_value = shifted;
      case (size_reg)
         2'd0: load_value = {{(DATA_W-8){~unsigned_reg & shifted[7]}}, shifted[7:0]};
         2'd1: load_value = {{(DATA_W-16){~unsigned_reg & shifted[15]}}, shifted[15:0]};
         2'd2: load_value = {{(DATA_W-32){~unsigned_reg & shifted[31]}}, shifted[31:0]};
         default: load_value = shifted;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept) state_next = misaligned ? DONE : REQ;
         REQ:  if (mem_req_ready) state_next = WAIT;
         WAIT: if (mem_resp_valid) state_next = DONE;
         DONE: if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         wmask_reg      <= '0;
         wen_reg        <= 1'b0;
         size_reg       <= '0;
         unsigned_reg   <= 1'b0;
         off_reg        <= '0;
         rd_reg         <= '0;
         rdata_reg      <= '0;
         out_wen_reg    <= 1'b0;
         misaligned_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            addr_reg       <= {in_addr[ADDR_W-1:3], 3'b000};
            wdata_reg      <= in_wdata << {in_addr[2:0], 3'b000};
            wmask_reg      <= in_wen ? lane_mask : 8'h00;
            wen_reg        <= in_wen;
            size_reg       <= in_size;
            unsigned_reg   <= in_unsigned;
            off_reg        <= in_addr[2:0];
            rd_reg         <= in_rd;
            rdata_reg      <= '0;
            out_wen_reg    <= !in_wen && !misaligned && (in_rd != 5'd0);
            misaligned_reg <= misaligned;
         end
         // Stores keep a zero result; only a load response updates it.
         if (state_reg == WAIT && mem_resp_valid && !wen_reg)
            rdata_reg <= load_value;
      end
   end

   assign mem_req_valid  = (state_reg == REQ);
   assign mem_req_addr   = addr_reg;
   assign mem_req_wen    = wen_reg;
   assign mem_req_wdata  = wdata_reg;
   assign mem_req_wmask  = wmask_reg;

   assign out_valid      = (state_reg == DONE);
   assign out_rd         = rd_reg;
   assign out_rdata      = rdata_reg;
   assign out_wen        = out_wen_reg;
   assign out_misaligned = misaligned_reg;

endmodule

// File: tb/tb_ysyx_22050612_load_store_unit.sv
// Randomized and directed bench for the load/store unit, checked against an
// arithmetic reference model of alignment, lane placement and load extension.
module tb_ysyx_22050612_load_store_unit;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_wen;
   logic [1:0]  in_size;
   logic        in_unsigned;
   logic [63:0] in_addr;
   logic [63:0] in_wdata;
   logic [4:0]  in_rd;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [63:0] mem_req_addr;
   logic        mem_req_wen;
   logic [63:0] mem_req_wdata;
   logic [7:0]  mem_req_wmask;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_rd;
   logic [63:0] out_rdata;
   logic        out_wen;
   logic        out_misaligned;

   int n_checks = 0;
   int n_fail   = 0;
   int req_count = 0;

   ysyx_22050612_load_store_unit #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_size(in_size),
      .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_rdata(out_rdata),
      .out_wen(out_wen), .out_misaligned(out_misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst && mem_req_valid && mem_req_ready) req_count++;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference load: pick the addressed bytes, then zero- or sign-extend by width.
   function automatic logic [63:0] model_load(input logic [63:0] mem, input int size,
                                              input bit uns, input int off);
      int bits;
      logic [63:0] v;
      logic [63:0] keep;
      bits = 8 * (1 << size);
      v = mem >> (8 * off);
      if (bits < 64) begin
         keep = (64'd1 << bits) - 64'd1;
         v = v & keep;
         if (!uns && v[bits-1]) v = v | ~keep;
      end
      return v;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_in_ready"}, in_ready, 1);
      check_eq({tag, "_req_valid"}, mem_req_valid, 0);
      check_eq({tag, "_req_wen"}, mem_req_wen, 0);
      check_eq({tag, "_req_addr"}, mem_req_addr, 0);
      check_eq({tag, "_req_wdata"}, mem_req_wdata, 0);
      check_eq({tag, "_req_wmask"}, mem_req_wmask, 0);
      check_eq({tag, "_out_valid"}, out_valid, 0);
      check_eq({tag, "_out_wen"}, out_wen, 0);
      check_eq({tag, "_out_mis"}, out_misaligned, 0);
      check_eq({tag, "_out_rd"}, out_rd, 0);
      check_eq({tag, "_out_rdata"}, out_rdata, 0);
   endtask

   // Drives one operation from the IDLE negedge and checks every cycle to retirement.
   task automatic run_op(input bit wen, input int size, input bit uns, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [4:0] rd, input logic [63:0] resp,
                         input int req_stall, input int resp_delay, input int out_stall);
      int bytes, off, base_cnt;
      bit mis;
      logic [63:0] e_addr, e_mask, e_wdata, e_rdata;
      bit e_wen;
      bytes   = 1 << size;
      off     = int'(addr[2:0]);
      mis     = (off % bytes) != 0;
      e_addr  = addr - 64'(off);
      e_mask  = wen ? ((((64'd1 << bytes) - 64'd1) << off) & 64'hFF) : 64'd0;
      e_wdata = wdata << (8 * off);
      e_rdata = (wen || mis) ? 64'd0 : model_load(resp, size, uns, off);
      e_wen   = !wen && !mis && (rd != 5'd0);

      check_eq("idle_in_ready", in_ready, 1);
      in_valid = 1'b1; in_wen = wen; in_size = 2'(size); in_unsigned = uns;
      in_addr = addr; in_wdata = wdata; in_rd = rd;
      base_cnt = req_count;
      @(negedge clk);
      in_valid = 1'b0;
      in_addr = {$urandom, $urandom}; in_wdata = {$urandom, $urandom}; in_rd = 5'($urandom);

      if (!mis) begin
         for (int i = 0; i <= req_stall; i++) begin
            check_eq("req_valid", mem_req_valid, 1);
            check_eq("req_addr", mem_req_addr, e_addr);
            check_eq("req_wen", mem_req_wen, wen);
            check_eq("req_wmask", mem_req_wmask, e_mask);
            if (wen) check_eq("req_wdata", mem_req_wdata, e_wdata);
            check_eq("req_in_ready", in_ready, 0);
            check_eq("req_out_valid", out_valid, 0);
            if (i == req_stall) mem_req_ready = 1'b1;
            else begin
               mem_resp_valid = 1'($urandom_range(0, 1));
               mem_resp_rdata = {$urandom, $urandom};
            end
            @(negedge clk);
            mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
         end
         for (int i = 0; i <= resp_delay; i++) begin
            check_eq("wait_req_valid", mem_req_valid, 0);
            check_eq("wait_out_valid", out_valid, 0);
            check_eq("wait_in_ready", in_ready, 0);
            if (i == resp_delay) begin
               mem_resp_valid = 1'b1; mem_resp_rdata = resp;
            end
            @(negedge clk);
            mem_resp_valid = 1'b0; mem_resp_rdata = {$urandom, $urandom};
         end
      end

      for (int i = 0; i <= out_stall; i++) begin
         check_eq("out_valid", out_valid, 1);
         check_eq("out_rd", out_rd, rd);
         check_eq("out_rdata", out_rdata, e_rdata);
         check_eq("out_wen", out_wen, e_wen);
         check_eq("out_misaligned", out_misaligned, mis);
         check_eq("done_in_ready", in_ready, 0);
         check_eq("done_req_valid", mem_req_valid, 0);
         if (i == out_stall) out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
      check_eq("retired_out_valid", out_valid, 0);
      check_eq("retired_in_ready", in_ready, 1);
      check_eq("req_count", 64'(req_count - base_cnt), mis ? 0 : 1);
      $display("op wen=%0d size=%0d uns=%0d addr=0x%0h rd=%0d mis=%0d rdata=0x%0h",
               wen, size, uns, addr, rd, mis, e_rdata);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 0; in_wen = 0; in_size = 0; in_unsigned = 0;
      in_addr = 0; in_wdata = 0; in_rd = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0; out_ready = 0;
      repeat (2) @(negedge clk);
      check_reset_outputs("por");
      rst = 1'b0;
      @(negedge clk);

      run_op(0, 2, 0, 64'h80000004, 64'h0, 5'd5, 64'hFEDCBA98_80000001, 0, 0, 0);
      run_op(1, 0, 0, 64'h80000003, 64'h12345678_9ABCDEAB, 5'd3, 64'h0, 0, 0, 0);
      run_op(0, 1, 1, 64'h80000006, 64'h0, 5'd7, 64'h8001_0000_0000_0000, 0, 0, 0);
      run_op(0, 1, 0, 64'h80000006, 64'h0, 5'd7, 64'h8001_0000_0000_0000, 0, 0, 0);
      run_op(0, 1, 0, 64'h80000006, 64'h0, 5'd0, 64'h8001_0000_0000_0000, 0, 0, 0);
      run_op(0, 2, 0, 64'h80000002, 64'h0, 5'd9, 64'h0, 0, 0, 0);
      run_op(0, 2, 0, 64'h80000010, 64'h0, 5'd12, 64'h11223344_87654321, 3, 0, 2);

      // Reset while a response is pending in WAIT.
      in_valid = 1; in_wen = 0; in_size = 2; in_unsigned = 0; in_addr = 64'h80000000; in_rd = 5'd4;
      @(negedge clk);
      in_valid = 0; mem_req_ready = 1;
      @(negedge clk);
      mem_req_ready = 0;
      check_eq("rst_wait_req_valid", mem_req_valid, 0);
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_wait");
      @(negedge clk);
      rst = 1'b0; mem_resp_valid = 1; mem_resp_rdata = 64'hDEADBEEF_CAFEF00D;
      @(negedge clk);
      mem_resp_valid = 0;
      check_eq("stale_out_valid", out_valid, 0);
      check_eq("stale_in_ready", in_ready, 1);
      @(negedge clk);
      check_eq("stale_out_valid2", out_valid, 0);
      run_op(0, 3, 0, 64'h80000008, 64'h0, 5'd10, 64'h89ABCDEF_01234567, 0, 0, 0);

      // Reset while the request is stalled must drop mem_req_valid without a clock.
      in_valid = 1; in_wen = 1; in_size = 3; in_addr = 64'h80000020; in_wdata = 64'h55; in_rd = 5'd1;
      @(negedge clk);
      in_valid = 0;
      check_eq("rst_req_valid_before", mem_req_valid, 1);
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_req");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int n = 0; n < 40; n++) begin
         run_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                64'h80000000 + 64'($urandom_range(0, 63)), {$urandom, $urandom},
                5'($urandom_range(0, 31)), {$urandom, $urandom},
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
